// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - shared types and constants for the immediate decode stage
package decode_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int INST_WIDTH   = 32;
    localparam int IMM_TYPE_NUM = 4;
    localparam int IMM_TYPE_W   = $clog2(IMM_TYPE_NUM);

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_S     = 2'b00,
        IMM_SHIFT = 2'b01,
        IMM_I     = 2'b10,
        IMM_U     = 2'b11
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        imm_type_e             imm_type;
        logic                  has_imm;
    } dec_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - fetch-side and execute-side handshakes of the decode stage
interface imm_decode_stage_if;
    import decode_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_inst;
    logic [DATA_WIDTH-1:0] in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_inst;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [IMM_TYPE_W-1:0] out_imm_type;
    logic                  out_has_imm;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_has_imm
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_has_imm
    );
endinterface

// File: rtl/imm_decode_stage_imm_type_decode.sv
// rtl/imm_decode_stage_imm_type_decode.sv - opcode classification and immediate formation
module imm_type_decode
    import decode_pkg::*;
(
    input  logic [INST_WIDTH-1:0] inst_i,
    output imm_type_e             imm_type_o,
    output logic                  has_imm_o,
    output logic [DATA_WIDTH-1:0] imm_o
);

    logic is_shift;
    assign is_shift = (inst_i[14:12] == 3'b001) || (inst_i[14:12] == 3'b101);

    // Classify opcode; unknown opcodes report no immediate and a zero value
    always_comb begin
        imm_type_o = IMM_S;
        has_imm_o  = 1'b0;
        imm_o      = '0;
        case (inst_i[6:0])
            OPC_LOAD, OPC_JALR: begin
                imm_type_o = IMM_I;
                has_imm_o  = 1'b1;
                imm_o      = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
            end
            OPC_OP_IMM: begin
                has_imm_o = 1'b1;
                if (is_shift) begin
                    imm_type_o = IMM_SHIFT;
                    imm_o      = {{(DATA_WIDTH-6){1'b0}}, inst_i[25:20]};
                end else begin
                    imm_type_o = IMM_I;
                    imm_o      = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_OP_IMM32: begin
                has_imm_o = 1'b1;
                if (is_shift) begin
                    // 32-bit shifts only have a 5-bit shamt
                    imm_type_o = IMM_SHIFT;
                    imm_o      = {{(DATA_WIDTH-5){1'b0}}, inst_i[24:20]};
                end else begin
                    imm_type_o = IMM_I;
                    imm_o      = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_STORE: begin
                imm_type_o = IMM_S;
                has_imm_o  = 1'b1;
                imm_o      = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type_o = IMM_U;
                has_imm_o  = 1'b1;
                imm_o      = {{(DATA_WIDTH-32){inst_i[31]}}, inst_i[31:12], 12'b0};
            end
            default: begin
                imm_type_o = IMM_S;
                has_imm_o  = 1'b0;
                imm_o      = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode stage with 2-entry skid buffer toward execute
module imm_decode_stage
    import decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    imm_decode_stage_if.slave    bus,
    output logic [31:0]          stall_cnt
);

    dec_entry_t  new_entry;
    dec_entry_t  e0_q, e0_d, e1_q, e1_d;
    buf_state_e  state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] stall_cnt_q;
    logic        acc, drn;

    imm_type_e             dec_type;
    logic                  dec_has_imm;
    logic [DATA_WIDTH-1:0] dec_imm;

    imm_type_decode u_imm_type_decode (
        .inst_i     (bus.in_inst),
        .imm_type_o (dec_type),
        .has_imm_o  (dec_has_imm),
        .imm_o      (dec_imm)
    );

    assign new_entry = '{inst: bus.in_inst, pc: bus.in_pc, imm: dec_imm,
                         imm_type: dec_type, has_imm: dec_has_imm};

    assign acc = bus.in_valid & in_ready_q;
    assign drn = out_valid_q & bus.out_ready;

    // Buffer state, entries and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            e0_q        <= '0;
            e1_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state: flush wins, then accept/drain; ready/valid follow the next state
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_ONE;
                        e0_d    = new_entry;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        e0_d = new_entry;
                    end else if (acc) begin
                        state_d = ST_FULL;
                        e1_d    = new_entry;
                    end else if (drn) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drn) begin
                        state_d = ST_ONE;
                        e0_d    = e1_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Saturating back-pressure counter, deliberately untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_inst     = e0_q.inst;
    assign bus.out_pc       = e0_q.pc;
    assign bus.out_imm      = e0_q.imm;
    assign bus.out_imm_type = e0_q.imm_type;
    assign bus.out_has_imm  = e0_q.has_imm;
    assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage
module tb_imm_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] stall_cnt;

    imm_decode_stage_if bus ();

    imm_decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [1:0]  ty;
        logic        has;
    } exp_t;

    exp_t        q[$];
    logic [31:0] stall_m;
    int          checks;
    int          failures;
    logic [63:0] pc_next;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sext12(input longint v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
        exp_t   e;
        int     op;
        int     f3;
        longint v;
        e.inst = inst; e.pc = pc; e.imm = 64'd0; e.ty = 2'd0; e.has = 1'b0;
        op = int'(inst % 128);
        f3 = int'((inst / 4096) % 8);
        if (op == 3 || op == 103) begin
            e.ty = 2'd2; e.has = 1'b1;
            e.imm = sext12(longint'(inst / 1048576));
        end else if (op == 19 || op == 27) begin
            e.has = 1'b1;
            if (f3 == 1 || f3 == 5) begin
                e.ty = 2'd1;
                e.imm = (op == 19) ? 64'((inst / 1048576) % 64) : 64'((inst / 1048576) % 32);
            end else begin
                e.ty = 2'd2;
                e.imm = sext12(longint'(inst / 1048576));
            end
        end else if (op == 35) begin
            e.ty = 2'd0; e.has = 1'b1;
            e.imm = sext12(longint'(inst / 33554432) * 32 + longint'((inst / 128) % 32));
        end else if (op == 55 || op == 23) begin
            e.ty = 2'd3; e.has = 1'b1;
            v = longint'(inst / 4096) * 4096;
            if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
            e.imm = v;
        end
        return e;
    endfunction

    task automatic check_state();
        check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check_eq("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        if (q.size() > 0) begin
            check_eq("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
            check_eq("out_pc", bus.out_pc, q[0].pc);
            check_eq("out_imm", bus.out_imm, q[0].imm);
            check_eq("out_imm_type", 64'(bus.out_imm_type), 64'(q[0].ty));
            check_eq("out_has_imm", 64'(bus.out_has_imm), 64'(q[0].has));
        end
    endtask

    // Called at a negedge: drive, clock, update model, then check at the next negedge
    task automatic cycle(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
        bit acc;
        bit drn;
        logic [63:0] pc;
        pc = pc_next;
        pc_next = pc_next + 64'd4;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
        @(posedge clk);
        if (q.size() > 0 && !rdy && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
        if (fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() < 2);
            drn = (q.size() > 0) && rdy;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(inst, pc));
        end
        @(negedge clk);
        check_state();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [8];
        logic [31:0] r;
        ops[0] = OPC_LOAD;  ops[1] = OPC_OP_IMM; ops[2] = OPC_OP_IMM32; ops[3] = OPC_STORE;
        ops[4] = OPC_LUI;   ops[5] = OPC_AUIPC;  ops[6] = OPC_JALR;     ops[7] = 7'b0110011;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 7)]};
    endfunction

    initial begin
        checks = 0; failures = 0; stall_m = 32'd0; pc_next = 64'h1000;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_stall", 64'(stall_cnt), 64'd0);
        check_eq("rst_out_imm", bus.out_imm, 64'd0);
        check_eq("rst_out_inst", 64'(bus.out_inst), 64'd0);
        check_eq("rst_out_pc", bus.out_pc, 64'd0);
        rst_n = 1'b1;

        // addi x1,x0,5
        cycle(1, 32'h0050_0093, 1, 0);
        check_eq("addi_imm", bus.out_imm, 64'd5);
        check_eq("addi_type", 64'(bus.out_imm_type), 64'd2);
        check_eq("addi_has", 64'(bus.out_has_imm), 64'd1);

        // sw, lui, slli back to back
        cycle(1, 32'hFE11_2E23, 1, 0);
        check_eq("sw_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("sw_type", 64'(bus.out_imm_type), 64'd0);
        cycle(1, 32'h8000_00B7, 1, 0);
        check_eq("lui_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);
        check_eq("lui_type", 64'(bus.out_imm_type), 64'd3);
        cycle(1, 32'h0030_1093, 1, 0);
        check_eq("slli_imm", bus.out_imm, 64'd3);
        check_eq("slli_type", 64'(bus.out_imm_type), 64'd1);
        cycle(0, 32'h0, 1, 0);

        // back-pressure: three offers, two accepted
        cycle(1, 32'h0010_0113, 0, 0);
        cycle(1, 32'h0020_0193, 0, 0);
        check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("bp_head", 64'(bus.out_inst), 64'h0010_0113);
        cycle(1, 32'h0030_0213, 0, 0);
        check_eq("bp_hold", 64'(bus.out_inst), 64'h0010_0113);
        repeat (3) cycle(0, 32'h0, 1, 0);

        // ONE state with simultaneous accept and drain
        cycle(1, rand_inst(), 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, rand_inst(), 1, 0);
            check_eq("one_valid", 64'(bus.out_valid), 64'd1);
        end
        repeat (2) cycle(0, 32'h0, 1, 0);

        // flush a full buffer while an input is offered
        cycle(1, rand_inst(), 0, 0);
        cycle(1, rand_inst(), 0, 0);
        cycle(1, rand_inst(), 0, 1);
        check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) cycle(0, 32'h0, 1, 0);

        // add has no immediate
        cycle(1, 32'h0020_81B3, 1, 0);
        check_eq("add_has", 64'(bus.out_has_imm), 64'd0);
        check_eq("add_imm", bus.out_imm, 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        end

        // asynchronous reset mid-stream
        cycle(1, rand_inst(), 0, 0);
        cycle(1, rand_inst(), 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_ready", 64'(bus.in_ready), 64'd1);
        check_eq("arst_stall", 64'(stall_cnt), 64'd0);
        check_eq("arst_imm", bus.out_imm, 64'd0);
        check_eq("arst_inst", 64'(bus.out_inst), 64'd0);
        q.delete();
        stall_m = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check_state();
        rst_n = 1'b1;
        cycle(1, 32'h0050_0093, 1, 0);
        cycle(0, 32'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
